decode_stage_hz: RTL and testbench

Parametrised decode stage (ID) plus ID/EX pipeline register for the RISC-V pipelined core.
- Integrates the register file with write-through bypass from the W stage.
- Detects load-use hazards and inserts bubbles.
- Supports an external stall (hold) and a flush (branch redirect).
- Control decode stays external: a packed control bundle arrives on CtrlD, so the stage is independent of the ISA subset.

---
 rtl/decode_stage_hz.sv | 148 ++++++++++++++
 tb/tb_decode_stage_hz.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_hz.sv
// rtl/decode_stage_hz.sv - RISC-V decode stage with register file, load-use hazard detection and ID/EX register
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-low reset
//   InstrD, ValidD             instruction in decode and its valid flag
//   PCD, PCPlus4D              PC and PC+4 of the decode instruction
//   CtrlD, ImmD                externally decoded control bundle and extended immediate
//   RegWriteW, RDW, ResultW    write-back port (also bypassed into same-cycle reads)
//   StallE, FlushE             hold / squash of the ID/EX register
//   StallD                     hold request for PC and IF/ID
//   ValidE ... PCPlus4E        registered ID/EX fields
//   BubbleCnt                  saturating count of load-use bubbles inserted

module decode_stage_hz #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int CTRL_W   = 8,
    parameter int LOAD_BIT = 1,
    parameter int PERF_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       InstrD,
    input  logic              ValidD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [XLEN-1:0]   ImmD,
    input  logic              RegWriteW,
    input  logic [4:0]        RDW,
    input  logic [XLEN-1:0]   ResultW,
    input  logic              StallE,
    input  logic              FlushE,
    output logic              StallD,
    output logic              ValidE,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [XLEN-1:0]   RD1_E,
    output logic [XLEN-1:0]   RD2_E,
    output logic [XLEN-1:0]   ImmE,
    output logic [4:0]        RS1_E,
    output logic [4:0]        RS2_E,
    output logic [4:0]        RD_E,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [PERF_W-1:0] BubbleCnt
);

    localparam int        IDXW    = $clog2(NREGS);
    localparam logic [5:0] NREGS_L = 6'(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            hz;
    logic            unused_instr_bits;

    assign rs1 = InstrD[19:15];
    assign rs2 = InstrD[24:20];
    assign rd  = InstrD[11:7];

    // Opcode/funct bits are decoded outside this stage.
    assign unused_instr_bits = ^{InstrD[31:25], InstrD[14:12], InstrD[6:0]};

    // x0 and indices beyond the implemented file (RV32E) are hard zero.
    function automatic logic in_file(input logic [4:0] idx);
        return (idx != 5'd0) && ({1'b0, idx} < NREGS_L);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWriteW && in_file(RDW)) begin
            regs[RDW[IDXW-1:0]] <= ResultW;
        end
    end

    // Write-through: a write-back in the same cycle is visible to the read.
    always_comb begin
        rd1 = '0;
        if (in_file(rs1)) begin
            if (RegWriteW && (RDW == rs1)) begin
                rd1 = ResultW;
            end else begin
                rd1 = regs[rs1[IDXW-1:0]];
            end
        end
    end

    always_comb begin
        rd2 = '0;
        if (in_file(rs2)) begin
            if (RegWriteW && (RDW == rs2)) begin
                rd2 = ResultW;
            end else begin
                rd2 = regs[rs2[IDXW-1:0]];
            end
        end
    end

    // rs2 is compared for every format; a false match only costs one bubble.
    assign hz = ValidD && ValidE && CtrlE[LOAD_BIT] && (RD_E != 5'd0) &&
                ((RD_E == rs1) || (RD_E == rs2));

    assign StallD = hz || StallE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ValidE    <= 1'b0;
            CtrlE     <= '0;
            RD1_E     <= '0;
            RD2_E     <= '0;
            ImmE      <= '0;
            RS1_E     <= '0;
            RS2_E     <= '0;
            RD_E      <= '0;
            PCE       <= '0;
            PCPlus4E  <= '0;
            BubbleCnt <= '0;
        end else if (FlushE || !StallE) begin
            // Data fields load on flush, bubble and normal advance alike;
            // only the valid/control pair distinguishes them.
            RD1_E    <= rd1;
            RD2_E    <= rd2;
            ImmE     <= ImmD;
            RS1_E    <= rs1;
            RS2_E    <= rs2;
            RD_E     <= rd;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            if (FlushE || hz) begin
                ValidE <= 1'b0;
                CtrlE  <= '0;
            end else begin
                ValidE <= ValidD;
                CtrlE  <= ValidD ? CtrlD : '0;
            end
            if (!FlushE && hz && (BubbleCnt != {PERF_W{1'b1}})) begin
                BubbleCnt <= BubbleCnt + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_hz.sv
// tb/tb_decode_stage_hz.sv - scoreboard bench for decode_stage_hz (32-reg/16-bit and 16-reg/2-bit instances)

module tb_decode_stage_hz;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] InstrD;
    logic        ValidD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic [7:0]  CtrlD;
    logic [31:0] ImmD;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        StallE;
    logic        FlushE;

    logic        StallD0, ValidE0, StallD1, ValidE1;
    logic [7:0]  CtrlE0, CtrlE1;
    logic [31:0] RD1_E0, RD2_E0, ImmE0, PCE0, PCPlus4E0;
    logic [31:0] RD1_E1, RD2_E1, ImmE1, PCE1, PCPlus4E1;
    logic [4:0]  RS1_E0, RS2_E0, RD_E0, RS1_E1, RS2_E1, RD_E1;
    logic [15:0] BubbleCnt0;
    logic [1:0]  BubbleCnt1;

    decode_stage_hz #(.XLEN(32), .NREGS(32), .CTRL_W(8), .LOAD_BIT(1), .PERF_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .CtrlD(CtrlD), .ImmD(ImmD), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .StallE(StallE), .FlushE(FlushE), .StallD(StallD0), .ValidE(ValidE0), .CtrlE(CtrlE0),
        .RD1_E(RD1_E0), .RD2_E(RD2_E0), .ImmE(ImmE0), .RS1_E(RS1_E0), .RS2_E(RS2_E0),
        .RD_E(RD_E0), .PCE(PCE0), .PCPlus4E(PCPlus4E0), .BubbleCnt(BubbleCnt0)
    );

    decode_stage_hz #(.XLEN(32), .NREGS(16), .CTRL_W(8), .LOAD_BIT(1), .PERF_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .CtrlD(CtrlD), .ImmD(ImmD), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .StallE(StallE), .FlushE(FlushE), .StallD(StallD1), .ValidE(ValidE1), .CtrlE(CtrlE1),
        .RD1_E(RD1_E1), .RD2_E(RD2_E1), .ImmE(ImmE1), .RS1_E(RS1_E1), .RS2_E(RS2_E1),
        .RD_E(RD_E1), .PCE(PCE1), .PCPlus4E(PCPlus4E1), .BubbleCnt(BubbleCnt1)
    );

    typedef struct packed {
        logic        valid;
        logic [7:0]  ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [15:0] bub;
    } e_t;

    // Reference model: architectural register contents plus the expected EX-stage contents.
    logic [31:0] m_regs [2][32];
    e_t          m_e [2];
    e_t          q0[$];
    e_t          q1[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic e_t act_of(input int k);
        e_t a;
        if (k == 0) a = '{ValidE0, CtrlE0, RD1_E0, RD2_E0, ImmE0, RS1_E0, RS2_E0, RD_E0, PCE0, PCPlus4E0, BubbleCnt0};
        else        a = '{ValidE1, CtrlE1, RD1_E1, RD2_E1, ImmE1, RS1_E1, RS2_E1, RD_E1, PCE1, PCPlus4E1, {14'd0, BubbleCnt1}};
        return a;
    endfunction

    function automatic int nregs_of(input int k);
        return (k == 0) ? 32 : 16;
    endfunction

    function automatic logic [31:0] m_read(input int k, input logic [4:0] idx);
        if (idx == 5'd0 || int'(idx) >= nregs_of(k)) return 32'd0;
        if (RegWriteW && RDW == idx) return ResultW;
        return m_regs[k][idx];
    endfunction

    task automatic model_step(input int k, output logic sd);
        logic [4:0]  rs1, rs2, rd;
        logic [15:0] maxc;
        logic        hz;
        e_t          ld;
        rs1  = InstrD[19:15];
        rs2  = InstrD[24:20];
        rd   = InstrD[11:7];
        maxc = (k == 0) ? 16'hFFFF : 16'd3;
        hz   = ValidD && m_e[k].valid && m_e[k].ctrl[1] && m_e[k].rd != 0 &&
               (m_e[k].rd == rs1 || m_e[k].rd == rs2);
        sd   = hz || StallE;
        ld   = '{ValidD, ValidD ? CtrlD : 8'd0, m_read(k, rs1), m_read(k, rs2), ImmD,
                 rs1, rs2, rd, PCD, PCPlus4D, m_e[k].bub};
        if (FlushE || hz) begin
            ld.valid = 1'b0;
            ld.ctrl  = 8'd0;
        end
        if (!FlushE && hz && ld.bub != maxc) ld.bub = ld.bub + 16'd1;
        if (FlushE || !StallE) m_e[k] = ld;
        if (RegWriteW && RDW != 0 && int'(RDW) < nregs_of(k)) m_regs[k][RDW] = ResultW;
        if (k == 0) q0.push_back(m_e[k]);
        else        q1.push_back(m_e[k]);
    endtask

    task automatic compare(input int k, input e_t e);
        e_t a;
        a = act_of(k);
        check($sformatf("dut%0d ValidE", k), 64'(a.valid), 64'(e.valid));
        check($sformatf("dut%0d CtrlE", k), 64'(a.ctrl), 64'(e.ctrl));
        check($sformatf("dut%0d RD1_E", k), 64'(a.rd1), 64'(e.rd1));
        check($sformatf("dut%0d RD2_E", k), 64'(a.rd2), 64'(e.rd2));
        check($sformatf("dut%0d ImmE", k), 64'(a.imm), 64'(e.imm));
        check($sformatf("dut%0d RS1/RS2/RD_E", k), 64'({a.rs1, a.rs2, a.rd}), 64'({e.rs1, e.rs2, e.rd}));
        check($sformatf("dut%0d PCE/PCPlus4E", k), {a.pc, a.pc4}, {e.pc, e.pc4});
        check($sformatf("dut%0d BubbleCnt", k), 64'(a.bub), 64'(e.bub));
    endtask

    // Monitor: every cycle the outputs registered at the preceding edge are checked.
    always @(negedge clk) begin
        if (q0.size() > 0) compare(0, q0.pop_front());
        if (q1.size() > 0) compare(1, q1.pop_front());
    end

    function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'b0000011};
    endfunction

    task automatic set_in(input logic [31:0] instr, input logic vd, input logic [7:0] ctrl,
                          input logic [31:0] pc, input logic rw, input logic [4:0] rdw,
                          input logic [31:0] res, input logic st, input logic fl);
        InstrD = instr; ValidD = vd; CtrlD = ctrl; PCD = pc; PCPlus4D = pc + 32'd4;
        ImmD = pc ^ 32'hA5A5_0000; RegWriteW = rw; RDW = rdw; ResultW = res;
        StallE = st; FlushE = fl;
    endtask

    task automatic idle();
        set_in(32'd0, 1'b0, 8'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // One clock: check combinational StallD, record expectations, advance past the edge.
    task automatic tick();
        logic sd0, sd1;
        #1;
        model_step(0, sd0);
        model_step(1, sd1);
        check("dut0 StallD", 64'(StallD0), 64'(sd0));
        check("dut1 StallD", 64'(StallD1), 64'(sd1));
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("reset ValidE0", 64'(ValidE0), 64'd0);
        check("reset CtrlE0", 64'(CtrlE0), 64'd0);
        check("reset RD1_E0", 64'(RD1_E0), 64'd0);
        check("reset PCE0", 64'(PCE0), 64'd0);
        check("reset BubbleCnt0", 64'(BubbleCnt0), 64'd0);
        check("reset BubbleCnt1", 64'(BubbleCnt1), 64'd0);
        for (int k = 0; k < 2; k++) begin
            m_e[k] = '0;
            for (int i = 0; i < 32; i++) m_regs[k][i] = 32'd0;
        end
        q0.push_back('0);
        q1.push_back('0);
        idle();
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic logic [4:0] pick_reg();
        logic [4:0] set [6];
        set = '{5'd0, 5'd3, 5'd5, 5'd15, 5'd20, 5'd31};
        return set[$urandom_range(0, 5)];
    endfunction

    logic [15:0] bc_before;

    initial begin
        rst = 1'b0;
        idle();
        @(negedge clk);
        #1;
        do_reset();

        // After reset x5 reads zero.
        set_in(mk(5'd5, 5'd0, 5'd1), 1'b1, 8'h00, 32'h10, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        check("x5 after reset", 64'(RD1_E0), 64'd0);

        // Same-cycle write-back bypass.
        set_in(mk(5'd5, 5'd0, 5'd1), 1'b1, 8'h00, 32'h14, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        tick();
        check("bypass RD1_E0", 64'(RD1_E0), 64'hDEADBEEF);
        check("bypass RD1_E1", 64'(RD1_E1), 64'hDEADBEEF);

        // x0 write is ignored.
        set_in(mk(5'd0, 5'd0, 5'd1), 1'b1, 8'h00, 32'h18, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b0);
        tick();
        set_in(mk(5'd0, 5'd0, 5'd1), 1'b1, 8'h00, 32'h1C, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        check("x0 read", 64'(RD1_E0), 64'd0);

        // Load-use: load rd=3 then consumer of rs2=3.
        set_in(mk(5'd0, 5'd0, 5'd3), 1'b1, 8'h02, 32'h20, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        set_in(mk(5'd1, 5'd3, 5'd4), 1'b1, 8'h01, 32'h24, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        #1;
        check("load-use StallD", 64'(StallD0), 64'd1);
        tick();
        check("bubble ValidE", 64'(ValidE0), 64'd0);
        check("bubble CtrlE", 64'(CtrlE0), 64'd0);
        check("bubble BubbleCnt", 64'(BubbleCnt0), 64'd1);
        check("after bubble StallD", 64'(StallD0), 64'd0);
        tick();
        check("consumer ValidE", 64'(ValidE0), 64'd1);
        check("consumer PCE", 64'(PCE0), 64'h24);

        // Load to x0 never stalls.
        set_in(mk(5'd0, 5'd0, 5'd0), 1'b1, 8'h02, 32'h28, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        set_in(mk(5'd0, 5'd0, 5'd4), 1'b1, 8'h01, 32'h2C, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        #1;
        check("rd0 no stall", 64'(StallD0), 64'd0);
        tick();

        // Flush beats stall and hazard; counter untouched.
        set_in(mk(5'd0, 5'd0, 5'd3), 1'b1, 8'h02, 32'h30, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        bc_before = BubbleCnt0;
        set_in(mk(5'd3, 5'd0, 5'd4), 1'b1, 8'h01, 32'h34, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        tick();
        check("flush ValidE", 64'(ValidE0), 64'd0);
        check("flush CtrlE", 64'(CtrlE0), 64'd0);
        check("flush BubbleCnt", 64'(BubbleCnt0), 64'(bc_before));

        // Three stall cycles hold the EX stage.
        set_in(mk(5'd1, 5'd2, 5'd6), 1'b1, 8'h81, 32'h100, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(mk(5'd7, 5'd8, 5'd9), 1'b1, 8'h44, 32'h200 + 32'(i * 4), 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
            #1;
            check("stall StallD", 64'(StallD0), 64'd1);
            tick();
            check("stall PCE", 64'(PCE0), 64'h100);
            check("stall CtrlE", 64'(CtrlE0), 64'h81);
        end

        // Indices beyond a 16-entry file read zero.
        set_in(mk(5'd0, 5'd0, 5'd1), 1'b1, 8'h00, 32'h40, 1'b1, 5'd20, 32'h55, 1'b0, 1'b0);
        tick();
        set_in(mk(5'd20, 5'd0, 5'd1), 1'b1, 8'h00, 32'h44, 1'b1, 5'd15, 32'h66, 1'b0, 1'b0);
        tick();
        check("x20 in 16-reg", 64'(RD1_E1), 64'd0);
        check("x20 in 32-reg", 64'(RD1_E0), 64'h55);
        set_in(mk(5'd15, 5'd0, 5'd1), 1'b1, 8'h00, 32'h48, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        check("x15 in 16-reg", 64'(RD1_E1), 64'h66);

        // Saturation of the 2-bit counter.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(mk(5'd0, 5'd0, 5'd3), 1'b1, 8'h02, 32'h50, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
            tick();
            set_in(mk(5'd3, 5'd0, 5'd7), 1'b1, 8'h00, 32'h54, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
            tick();
            check("sat BubbleCnt1", 64'(BubbleCnt1), (i < 3) ? 64'(i + 1) : 64'd3);
            check("sat BubbleCnt0", 64'(BubbleCnt0), 64'(i + 1));
            tick();
        end

        // Randomized traffic, including an occasional mid-stream reset.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                set_in(mk(pick_reg(), pick_reg(), pick_reg()),
                       ($urandom_range(0, 9) < 8), 8'($urandom),
                       32'($urandom) & 32'hFFFF_FFFC,
                       ($urandom_range(0, 1) == 1), pick_reg(), $urandom,
                       ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) == 0));
                tick();
            end
        end

        idle();
        for (int i = 0; i < 4 && (q0.size() + q1.size()) > 0; i++) @(negedge clk);
        check("scoreboard drained", 64'(q0.size() + q1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
